// File: rtl/camera_control_multirow.sv
// -----------------------------------------------------------------------------
// camera_control_multirow
//
// Sequences erase, expose and row-by-row ADC readout for a pixel array of ROWS
// rows. The exposure time is adjustable from push-buttons while idle and
// saturates at EXP_MIN/EXP_MAX. Single-shot frames are started with init. In
// continuous mode a short erase phase separates frames. Status outputs report
// busy and a one-cycle end-of-frame pulse.
//
// Frame timeline (cycles):
//   EXPOSE  : exp_time
//   READOUT : ROWS * (ADC_CYCLES + 1)   (one settle cycle + ADC_CYCLES per row)
//   ERASE   : ERASE_CYCLES              (continuous mode only, between frames)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   init        in   start a frame (sampled in IDLE only)
//   exp_inc     in   +1 exposure per cycle held (IDLE only)
//   exp_dec     in   -1 exposure per cycle held (IDLE only)
//   cont        in   continuous frames; sampled at the end of each readout
//   nre         out  active-low row enables, at most one low
//   expose      out  pixel expose control
//   erase       out  pixel erase control
//   adc         out  ADC convert strobe
//   busy        out  high whenever the controller is not idle
//   frame_done  out  one-cycle pulse on the last readout cycle of a frame
//   exp_time    out  current exposure setting
//
// All outputs are registers loaded from the next-state decode, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module camera_control_multirow #(
    parameter int ROWS         = 2,
    parameter int EXP_W        = 5,
    parameter int EXP_MIN      = 2,
    parameter int EXP_MAX      = 30,
    parameter int EXP_DEFAULT  = 2,
    parameter int ADC_CYCLES   = 2,
    parameter int ERASE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             exp_inc,
    input  logic             exp_dec,
    input  logic             cont,
    output logic [ROWS-1:0]  nre,
    output logic             expose,
    output logic             erase,
    output logic             adc,
    output logic             busy,
    output logic             frame_done,
    output logic [EXP_W-1:0] exp_time
);

    // Counter widths
    localparam int SLOT_W  = $clog2(ADC_CYCLES + 1);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);

    // Sized constants so every comparison is width-matched
    localparam logic [EXP_W-1:0]   EXP_MIN_V     = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0]   EXP_MAX_V     = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0]   EXP_DEFAULT_V = EXP_W'(EXP_DEFAULT);
    localparam logic [SLOT_W-1:0]  SLOT_LAST     = SLOT_W'(ADC_CYCLES);
    localparam logic [ROW_W-1:0]   ROW_LAST      = ROW_W'(ROWS - 1);
    localparam logic [ERASE_W-1:0] ERASE_LAST    = ERASE_W'(ERASE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPOSE,
        S_READOUT,
        S_ERASE
    } state_t;

    // Registered state and counters
    state_t             state;
    logic [EXP_W-1:0]   exp_cnt;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [ROW_W-1:0]   row_cnt;
    logic [ERASE_W-1:0] erase_cnt;

    // Next-state values
    state_t             nxt_state;
    logic [EXP_W-1:0]   nxt_exp_time;
    logic [EXP_W-1:0]   nxt_exp_cnt;
    logic [SLOT_W-1:0]  nxt_slot;
    logic [ROW_W-1:0]   nxt_row;
    logic [ERASE_W-1:0] nxt_erase_cnt;

    // Next-cycle output values, decoded from the next state
    logic [ROWS-1:0]    nxt_nre;
    logic               nxt_expose;
    logic               nxt_erase;
    logic               nxt_adc;
    logic               nxt_busy;
    logic               nxt_frame_done;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned; otherwise synthesis would infer a latch.
        nxt_state     = state;
        nxt_exp_time  = exp_time;
        nxt_exp_cnt   = exp_cnt;
        nxt_slot      = slot_cnt;
        nxt_row       = row_cnt;
        nxt_erase_cnt = erase_cnt;

        case (state)
            S_IDLE: begin
                // init wins over the exposure buttons in the same cycle
                if (init) begin
                    nxt_state   = S_EXPOSE;
                    nxt_exp_cnt = '0;
                end else if (exp_inc && !exp_dec) begin
                    if (exp_time < EXP_MAX_V)
                        nxt_exp_time = exp_time + EXP_W'(1);
                end else if (exp_dec && !exp_inc) begin
                    if (exp_time > EXP_MIN_V)
                        nxt_exp_time = exp_time - EXP_W'(1);
                end
            end

            S_EXPOSE: begin
                // exp_cnt runs 0..exp_time-1; exp_time is frozen while busy
                if (exp_cnt == exp_time - EXP_W'(1)) begin
                    nxt_state = S_READOUT;
                    nxt_slot  = '0;
                    nxt_row   = '0;
                end else begin
                    nxt_exp_cnt = exp_cnt + EXP_W'(1);
                end
            end

            S_READOUT: begin
                if (slot_cnt == SLOT_LAST) begin
                    nxt_slot = '0;
                    if (row_cnt == ROW_LAST) begin
                        // End of frame: cont is only looked at here, so a
                        // running frame always completes.
                        nxt_row       = '0;
                        nxt_erase_cnt = '0;
                        nxt_state     = cont ? S_ERASE : S_IDLE;
                    end else begin
                        nxt_row = row_cnt + ROW_W'(1);
                    end
                end else begin
                    nxt_slot = slot_cnt + SLOT_W'(1);
                end
            end

            S_ERASE: begin
                if (erase_cnt == ERASE_LAST) begin
                    nxt_state   = S_EXPOSE;
                    nxt_exp_cnt = '0;
                end else begin
                    nxt_erase_cnt = erase_cnt + ERASE_W'(1);
                end
            end

            default: nxt_state = S_IDLE;
        endcase

        // Output decode for the coming cycle
        nxt_expose     = (nxt_state == S_EXPOSE);
        nxt_erase      = (nxt_state == S_IDLE) || (nxt_state == S_ERASE);
        nxt_busy       = (nxt_state != S_IDLE);
        nxt_adc        = (nxt_state == S_READOUT) && (nxt_slot != '0);
        nxt_frame_done = (nxt_state == S_READOUT) && (nxt_row == ROW_LAST) &&
                         (nxt_slot == SLOT_LAST);
        for (int r = 0; r < ROWS; r++)
            nxt_nre[r] = !((nxt_state == S_READOUT) && (nxt_row == ROW_W'(r)));
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            exp_time   <= EXP_DEFAULT_V;
            exp_cnt    <= '0;
            slot_cnt   <= '0;
            row_cnt    <= '0;
            erase_cnt  <= '0;
            nre        <= '1;
            expose     <= 1'b0;
            erase      <= 1'b1;
            adc        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state      <= nxt_state;
            exp_time   <= nxt_exp_time;
            exp_cnt    <= nxt_exp_cnt;
            slot_cnt   <= nxt_slot;
            row_cnt    <= nxt_row;
            erase_cnt  <= nxt_erase_cnt;
            nre        <= nxt_nre;
            expose     <= nxt_expose;
            erase      <= nxt_erase;
            adc        <= nxt_adc;
            busy       <= nxt_busy;
            frame_done <= nxt_frame_done;
        end
    end

endmodule
